// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
package if_pkg;

  localparam int unsigned IF_XLEN = 32;

  localparam logic [IF_XLEN-1:0] IF_NOP     = 32'h0000_0013;
  localparam logic [IF_XLEN-1:0] IF_PC_STEP = 32'd4;

  // One queued fetch: program counter and the instruction word at it.
  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction fetch queue.
interface if_queue_if #(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          start_i;
  logic          flush_i;
  logic          valid_i;
  logic [31:0]   pc_i;
  logic [31:0]   instr_i;
  logic          ready_o;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   pc_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_plus4_o;
  logic [CW-1:0] count_o;

  // Core side: fetch path, decode stage and control.
  modport master (
    output start_i, flush_i, valid_i, pc_i, instr_i, ready_i,
    input  ready_o, valid_o, pc_o, instr_o, pc_plus4_o, count_o
  );

  // Queue side.
  modport slave (
    input  start_i, flush_i, valid_i, pc_i, instr_i, ready_i,
    output ready_o, valid_o, pc_o, instr_o, pc_plus4_o, count_o
  );

endinterface

// File: rtl/if_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, combinational read,
// asynchronously cleared.
module if_queue_mem
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  if_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output if_entry_t     rdata
);

  if_entry_t mem_q [DEPTH];

  // Write port; reset zeroes every entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue between the PC register and decode.
// Optional feature macro: IF_QUEUE_BYPASS_EN (empty-queue fetch-to-decode
// combinational bypass).
module if_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = IF_NOP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;

  logic      empty;
  logic      full;
  logic      ready;
  logic      stored_valid;
  logic      bypass;
  logic      push;
  logic      pop;
  if_entry_t wr_entry;
  if_entry_t rd_entry;
  if_entry_t head;

  // Handshake terms; ready never looks at decode's ready_i.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CW'(DEPTH));
    ready        = bus.start_i & ~bus.flush_i & ~full;
    stored_valid = ~empty & ~bus.flush_i;
`ifdef IF_QUEUE_BYPASS_EN
    bypass       = empty & bus.valid_i & ready & bus.ready_i;
`else
    bypass       = 1'b0;
`endif
    push         = bus.valid_i & ready & ~bypass;
    pop          = stored_valid & bus.ready_i;
  end

  // Pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (bus.flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Pack the offered fetch into an entry.
  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = bus.pc_i;
    wr_entry.instr = bus.instr_i;
  end

  if_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Head selection: bypassed fetch when taken, else stored head.
  always_comb begin
    head = rd_entry;
    if (bypass) begin
      head = wr_entry;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = stored_valid | bypass;
  assign bus.pc_o       = head.pc;
  assign bus.instr_o    = (stored_valid | bypass) ? head.instr : NOP;
  assign bus.pc_plus4_o = head.pc + IF_PC_STEP;
  assign bus.count_o    = count_q;

endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue with a scoreboard of expected heads.
module tb_if_queue;
  import if_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_queue_if #(.DEPTH(DEPTH)) bus ();

  if_queue #(.DEPTH(DEPTH), .NOP(IF_NOP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  if_entry_t   sb[$];
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          n_popped = 0;
  logic [31:0] last_pc  = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h00A0_0093 ^ {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic drive_idle();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.start_i = 1'b1;
    bus.ready_i = 1'b0;
    bus.pc_i    = '0;
    bus.instr_i = '0;
  endtask

  task automatic offer(input logic [31:0] pc);
    bus.valid_i = 1'b1;
    bus.pc_i    = pc;
    bus.instr_i = instr_of(pc);
  endtask

  // One clock: check outputs against the scoreboard, then advance it.
  task automatic step();
    logic      exp_ready, exp_valid, byp, do_push, do_pop;
    if_entry_t exp_head, e;
    #1;
    byp = 1'b0;
`ifdef IF_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && bus.valid_i && bus.start_i && !bus.flush_i && bus.ready_i;
`endif
    exp_ready = bus.start_i && !bus.flush_i && (sb.size() < DEPTH);
    exp_valid = ((sb.size() != 0) && !bus.flush_i) || byp;
    n_tests++;
    if (bus.ready_o !== exp_ready) begin
      n_fail++; $display("FAIL ready_o: got %b exp %b", bus.ready_o, exp_ready);
    end
    n_tests++;
    if (bus.valid_o !== exp_valid) begin
      n_fail++; $display("FAIL valid_o: got %b exp %b", bus.valid_o, exp_valid);
    end
    n_tests++;
    if (bus.count_o !== 3'(sb.size())) begin
      n_fail++; $display("FAIL count_o: got %0d exp %0d", bus.count_o, sb.size());
    end
    if (exp_valid) begin
      if (byp) begin
        exp_head.pc = bus.pc_i; exp_head.instr = bus.instr_i;
      end else begin
        exp_head = sb[0];
      end
      n_tests++;
      if (bus.pc_o !== exp_head.pc || bus.instr_o !== exp_head.instr) begin
        n_fail++;
        $display("FAIL head: got pc %h instr %h exp pc %h instr %h",
                 bus.pc_o, bus.instr_o, exp_head.pc, exp_head.instr);
      end
      n_tests++;
      if (bus.pc_plus4_o !== exp_head.pc + 32'd4) begin
        n_fail++; $display("FAIL pc_plus4: got %h exp %h", bus.pc_plus4_o, exp_head.pc + 32'd4);
      end
    end else begin
      n_tests++;
      if (bus.instr_o !== IF_NOP) begin
        n_fail++; $display("FAIL nop: got %h exp %h", bus.instr_o, IF_NOP);
      end
    end
    do_pop  = exp_valid && bus.ready_i && !byp;
    do_push = bus.valid_i && exp_ready && !byp;
    e.pc    = bus.pc_i;
    e.instr = bus.instr_i;
    if (exp_valid && bus.ready_i) begin
      n_popped++;
      last_pc = exp_head.pc;
    end
    @(posedge clk);
    if (bus.flush_i) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #1;
    n_tests++;
    if (bus.count_o !== '0 || bus.valid_o !== 1'b0 || bus.instr_o !== IF_NOP) begin
      n_fail++; $display("FAIL por_state: got cnt %0d v %b instr %h exp 0 0 %h",
                         bus.count_o, bus.valid_o, bus.instr_o, IF_NOP);
    end
    n_tests++;
    if (bus.pc_o !== 32'h0 || bus.pc_plus4_o !== 32'h4 || bus.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL por_pc: got pc %h p4 %h rdy %b exp 0 4 1",
                         bus.pc_o, bus.pc_plus4_o, bus.ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h1000 + 32'(4 * i));
      step();
    end
    drive_idle();
    #1;
    n_tests++;
    if (bus.count_o !== 3'd3) begin
      n_fail++; $display("FAIL prefill_cnt: got %0d exp 3", bus.count_o);
    end
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    n_tests++;
    if (bus.count_o !== '0 || bus.valid_o !== 1'b0 || bus.instr_o !== IF_NOP) begin
      n_fail++; $display("FAIL async_rst: got cnt %0d v %b instr %h exp 0 0 %h",
                         bus.count_o, bus.valid_o, bus.instr_o, IF_NOP);
    end
    n_tests++;
    if (bus.pc_o !== 32'h0 || bus.pc_plus4_o !== 32'h4) begin
      n_fail++; $display("FAIL async_rst_pc: got pc %h p4 %h exp 0 4", bus.pc_o, bus.pc_plus4_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_full();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i));
      step();
    end
    offer(32'h10);
    #1;
    n_tests++;
    if (bus.count_o !== 3'd4 || bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full: got cnt %0d rdy %b exp 4 0", bus.count_o, bus.ready_o);
    end
    step();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (bus.count_o !== '0 || last_pc !== 32'h0C) begin
      n_fail++; $display("FAIL drain_full: got cnt %0d last %h exp 0 0000000c", bus.count_o, last_pc);
    end
  endtask

  task automatic test_wraparound();
    int pushed = 0;
    int base   = n_popped;
    drive_idle();
    for (int c = 0; c < 60 && (pushed < 10 || sb.size() != 0); c++) begin
      bus.valid_i = (pushed < 10) && (sb.size() < 3);
      bus.pc_i    = 32'h100 + 32'(4 * pushed);
      bus.instr_i = instr_of(bus.pc_i);
      bus.ready_i = (pushed >= 10) || (sb.size() >= 3) || ((sb.size() >= 1) && (c % 2 == 1));
      if (bus.valid_i) pushed++;
      step();
    end
    n_tests++;
    if (n_popped - base != 10 || bus.count_o !== '0) begin
      n_fail++; $display("FAIL wrap: got popped %0d cnt %0d exp 10 0", n_popped - base, bus.count_o);
    end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    offer(32'h200); step();
    offer(32'h204); step();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(32'h208 + 32'(4 * i));
      step();
    end
    #1;
    n_tests++;
    if (bus.count_o !== 3'd2) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d exp 2", bus.count_o);
    end
    bus.valid_i = 1'b0;
    step(); step();
  endtask

  task automatic test_flush();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      offer(32'h300 + 32'(4 * i));
      step();
    end
    offer(32'h30);
    bus.flush_i = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    n_tests++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: got v %b rdy %b exp 0 0", bus.valid_o, bus.ready_o);
    end
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    #1;
    n_tests++;
    if (bus.count_o !== '0) begin
      n_fail++; $display("FAIL flush_cnt: got %0d exp 0", bus.count_o);
    end
    offer(32'h40);
    step();
    bus.valid_i = 1'b0;
    #1;
    n_tests++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h40) begin
      n_fail++; $display("FAIL post_flush_head: got v %b pc %h exp 1 00000040", bus.valid_o, bus.pc_o);
    end
    bus.ready_i = 1'b1;
    step();
  endtask

  task automatic test_start_gate();
    drive_idle();
    offer(32'h500); step();
    offer(32'h504); step();
    bus.start_i = 1'b0;
    bus.ready_i = 1'b1;
    offer(32'h600);
    #1;
    n_tests++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL start_rdy: got %b exp 0", bus.ready_o);
    end
    step(); step();
    n_tests++;
    if (bus.count_o !== '0) begin
      n_fail++; $display("FAIL start_drain: got %0d exp 0", bus.count_o);
    end
    bus.start_i = 1'b1;
    bus.valid_i = 1'b0;
  endtask

`ifdef IF_QUEUE_BYPASS_EN
  task automatic test_bypass();
    drive_idle();
    bus.ready_i = 1'b1;
    offer(32'h80);
    #1;
    n_tests++;
    if (bus.pc_o !== 32'h80 || bus.valid_o !== 1'b1 || bus.count_o !== '0) begin
      n_fail++; $display("FAIL bypass: got pc %h v %b cnt %0d exp 00000080 1 0",
                         bus.pc_o, bus.valid_o, bus.count_o);
    end
    step();
    bus.valid_i = 1'b0;
    #1;
    n_tests++;
    if (bus.count_o !== '0) begin
      n_fail++; $display("FAIL bypass_cnt: got %0d exp 0", bus.count_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_fill_full();
    test_wraparound();
    test_back_to_back();
    test_flush();
    test_start_gate();
`ifdef IF_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_queue.md
# if_queue

Instruction fetch queue between the program counter register and the decode stage. Captures {PC, instruction} pairs from the fetch path into a small FIFO. Presents them to decode with a valid/ready handshake, and drops everything in flight on a branch or jump flush. Its `ready_o` is the term that gates the PC register's write enable, so fetch stalls whenever the queue is full.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `NOP`, 32'h0000_0013: instruction emitted on `instr_o` whenever `valid_o` is 0.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  core run enable; when 0, no pushes are accepted.
- `flush_i`  in  1  discard all queued and incoming entries (taken branch/jump).
- `valid_i`  in  1  fetch path offers `pc_i`/`instr_i` this cycle.
- `pc_i`  in  32  PC of the offered instruction.
- `instr_i`  in  32  offered instruction word.
- `ready_o`  out  1  queue accepts a push this cycle; drives the PC write enable.
- `valid_o`  out  1  head entry is valid for decode.
- `ready_i`  in  1  decode consumes the head this cycle (not stalled).
- `pc_o`  out  32  PC of the head entry.
- `instr_o`  out  32  head instruction; `NOP` when `valid_o`=0.
- `pc_plus4_o`  out  32  `pc_o` + 4, modulo 2^32.
- `count_o`  out  clog2(DEPTH)+1  current occupancy.

## Operation
- Handshake rules:
  - `ready_o` = `start_i` & ~`flush_i` & (`count_o` < `DEPTH`).
  - A push occurs when `valid_i` & `ready_o`.
  - `valid_o` = (`count_o` != 0) & ~`flush_i`.
  - A pop occurs when `valid_o` & `ready_i`.
- Storage and pointers:
  - Entries are stored at the write pointer and read at the read pointer.
  - Both pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy updates:
  - Push only: `count_o` +1.
  - Pop only: `count_o` −1.
  - Push and pop in the same cycle: `count_o` unchanged, both pointers advance. This is legal at any occupancy below DEPTH.
- Full queue: `ready_o`=0 and `instr_i` is ignored even if a pop occurs in that cycle. There is no full-queue pass-through.
- Flush has priority over everything else:
  - At the next edge, `count_o` becomes 0 and both pointers become 0.
  - Any push offered in the flush cycle is discarded.
  - No pop occurs in the flush cycle.
- `start_i`=0 blocks pushes only. Pops continue, so the queue drains.
- Output values:
  - `pc_o` shows the head entry's stored PC.
  - `instr_o` is muxed to `NOP` when the queue is invalid.
  - `pc_plus4_o` is derived combinationally from `pc_o`.

## Timing
- On reset:
  - `count_o`=0, pointers 0, all storage 0.
  - `valid_o`=0, `pc_o`=0, `pc_plus4_o`=4, `instr_o`=`NOP`.
  - `ready_o`=`start_i`.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge.
- Latency: a push at edge N appears at the head with `valid_o`=1 in cycle N+1, when the queue was empty; the IF_QUEUE_BYPASS_EN bypass shortens this (see Configuration).
- `ready_o` and `valid_o` are combinational in `flush_i`.
- `ready_o` must not depend on `ready_i`, to keep the PC-enable path short.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro `IF_QUEUE_BYPASS_EN`.
- When defined: if `count_o`=0, `valid_i`=1, `start_i`=1, `flush_i`=0 and `ready_i`=1, then:
  - `pc_i`/`instr_i` drive the outputs combinationally.
  - `valid_o`=1 in the same cycle.
  - The entry is consumed without being written, and `count_o` stays 0.
  - If `ready_i`=0 under the same conditions, the entry is written normally.
- When undefined: no input-to-output combinational path; minimum latency is 1 cycle.

## Structure
- Package `if_pkg`:
  - `IF_NOP` constant (32'h0000_0013).
  - `if_entry_t` packed struct {pc[31:0], instr[31:0]}.
  - `IF_PC_STEP` constant (4).
- One sub-module, `if_queue_mem`:
  - DEPTH×`if_entry_t` register array.
  - One synchronous write port and one combinational read port.
  - Asynchronous clear on `rst_i`.
- Pointer, count and handshake logic live in `if_queue`.

## Test plan
- Reset: assert `rst_i` mid-fill with `count_o`=3 → `count_o`=0, `valid_o`=0, `instr_o`=32'h0000_0013 immediately; `pc_o`=0, `pc_plus4_o`=4.
- Fill/full: with `ready_i`=0, push PCs 0x00, 0x04, 0x08, 0x0C → `count_o`=4, `ready_o`=0. A fifth offer (0x10) is dropped, and subsequent pops return 0x00…0x0C in order.
- Wrap-around: 10 pushes/pops with occupancy oscillating between 1 and 3 → output order matches input order across pointer wrap; no entry lost or duplicated.
- Simultaneous push/pop at `count_o`=2 for 5 cycles → `count_o` stays 2 and outputs stream in order.
- Flush: `count_o`=3 with a push offered and `flush_i`=1 → `valid_o`=0 and `ready_o`=0 that cycle; `count_o`=0 next cycle; the next push (PC 0x40) is the next valid head.
- `start_i`=0 with `count_o`=2 and `ready_i`=1 → `ready_o`=0; the queue drains to 0 in 2 cycles. With `IF_QUEUE_BYPASS_EN`, an empty queue with `valid_i`=`ready_i`=1 and PC 0x80 → `pc_o`=0x80 and `valid_o`=1 in the same cycle, with `count_o`=0.
